// File: rtl/gb_sweep_if.sv
// Channel-1 sweep bundle: frame-sequencer strobes, NR10/NR13/NR14 fields, and sweep results.
// Pure wiring, no latency.
// No backpressure: every signal is a level or a one-cycle strobe.
interface gb_sweep_if #(
    parameter int FREQ_W = 11
);
    logic              sweep_clk;
    logic              trigger;
    logic [2:0]        nr10_period;
    logic              nr10_negate;
    logic [2:0]        nr10_shift;
    logic [FREQ_W-1:0] freq_in;
    logic [FREQ_W-1:0] freq_out;
    logic              freq_update;
    logic              channel_disable;
    logic              sweep_enabled;

    // Register/sequencer side: drives strobes and NR10 fields, observes results
    modport master (
        output sweep_clk, trigger, nr10_period, nr10_negate, nr10_shift, freq_in,
        input  freq_out, freq_update, channel_disable, sweep_enabled
    );

    // Sweep unit side
    modport slave (
        input  sweep_clk, trigger, nr10_period, nr10_negate, nr10_shift, freq_in,
        output freq_out, freq_update, channel_disable, sweep_enabled
    );
endinterface

// File: rtl/gb_sweep_unit.sv
// Square-1 frequency sweep: shadow register, pace timer, calc/apply/check FSM, overflow disable.
// freq_update at T+2 after an expiring sweep_clk, follow-up check disable at T+3, trigger check at T+1.
// No backpressure: strobes arriving outside IDLE are dropped; pacing guarantees spacing.
module gb_sweep_unit #(
    parameter int FREQ_W    = 11,
    parameter int OVF_LIMIT = 2047
) (
    input  logic         clk,
    input  logic         reset,
    gb_sweep_if.slave    sw
);
    localparam int CALC_W = FREQ_W + 1;
    localparam logic [CALC_W-1:0] OVF_MAX = CALC_W'(OVF_LIMIT);

    typedef enum logic [1:0] {IDLE, CALC, APPLY, CHECK} state_t;

    state_t             state, state_nxt;
    logic [FREQ_W-1:0]  shadow, shadow_nxt;
    logic [FREQ_W-1:0]  freq_q, freq_nxt;
    logic [CALC_W-1:0]  new_freq, new_freq_nxt;
    logic [3:0]         timer, timer_nxt, timer_dec, reload;
    logic               en, en_nxt;
    logic               neg_used, neg_used_nxt;
    logic               neg_q;
    logic               upd_nxt, dis_nxt;
    logic               upd_q, dis_q;
    logic [CALC_W-1:0]  calc_now;
    logic               calc_ovf, neg_quirk;

    // Unsigned 12-bit sweep step; a right shift never exceeds the base, so subtraction cannot wrap
    function automatic logic [CALC_W-1:0] calc_sum(input logic [FREQ_W-1:0] base,
                                                   input logic [2:0] sh,
                                                   input logic neg);
        logic [CALC_W-1:0] b;
        logic [CALC_W-1:0] d;
        b = {1'b0, base};
        d = b >> sh;
        return neg ? (b - d) : (b + d);
    endfunction

    assign calc_now  = calc_sum(shadow, sw.nr10_shift, sw.nr10_negate);
    assign calc_ovf  = calc_now > OVF_MAX;
    assign reload    = (sw.nr10_period == 3'd0) ? 4'd8 : {1'b0, sw.nr10_period};
    assign timer_dec = timer - 4'd1;
    // Leaving negate mode after a negate calc has been used kills the channel
    assign neg_quirk = neg_q && !sw.nr10_negate && neg_used;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shadow   <= '0;
            freq_q   <= '0;
            new_freq <= '0;
            timer    <= '0;
            en       <= 1'b0;
            neg_used <= 1'b0;
            neg_q    <= 1'b0;
            upd_q    <= 1'b0;
            dis_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            shadow   <= shadow_nxt;
            freq_q   <= freq_nxt;
            new_freq <= new_freq_nxt;
            timer    <= timer_nxt;
            en       <= en_nxt;
            neg_used <= neg_used_nxt;
            neg_q    <= sw.nr10_negate;
            upd_q    <= upd_nxt;
            dis_q    <= dis_nxt;
        end
    end

    // Next-state and datapath updates; trigger overrides everything in flight
    always_comb begin
        state_nxt    = state;
        shadow_nxt   = shadow;
        freq_nxt     = freq_q;
        new_freq_nxt = new_freq;
        timer_nxt    = timer;
        en_nxt       = en;
        neg_used_nxt = neg_used;
        upd_nxt      = 1'b0;
        dis_nxt      = 1'b0;

        if (sw.trigger) begin
            shadow_nxt   = sw.freq_in;
            freq_nxt     = sw.freq_in;
            timer_nxt    = reload;
            neg_used_nxt = 1'b0;
            en_nxt       = (sw.nr10_period != 3'd0) || (sw.nr10_shift != 3'd0);
            state_nxt    = (sw.nr10_shift != 3'd0) ? CHECK : IDLE;
        end else begin
            if (neg_quirk) begin
                dis_nxt = 1'b1;
                en_nxt  = 1'b0;
            end
            case (state)
                IDLE: begin
                    if (sw.sweep_clk && timer != 4'd0) begin
                        timer_nxt = timer_dec;
                        if (timer_dec == 4'd0) begin
                            timer_nxt = reload;
                            if (en && sw.nr10_period != 3'd0) state_nxt = CALC;
                        end
                    end
                end
                CALC: begin
                    new_freq_nxt = calc_now;
                    if (sw.nr10_negate) neg_used_nxt = 1'b1;
                    state_nxt = APPLY;
                end
                APPLY: begin
                    state_nxt = IDLE;
                    if (new_freq > OVF_MAX) begin
                        dis_nxt = 1'b1;
                        en_nxt  = 1'b0;
                    end else if (sw.nr10_shift != 3'd0 && en_nxt) begin
                        shadow_nxt = new_freq[FREQ_W-1:0];
                        freq_nxt   = new_freq[FREQ_W-1:0];
                        upd_nxt    = 1'b1;
                        state_nxt  = CHECK;
                    end
                end
                CHECK: begin
                    if (sw.nr10_negate) neg_used_nxt = 1'b1;
                    if (calc_ovf) begin
                        dis_nxt = 1'b1;
                        en_nxt  = 1'b0;
                    end
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign sw.freq_out        = freq_q;
    assign sw.freq_update     = upd_q;
    assign sw.channel_disable = dis_q;
    assign sw.sweep_enabled   = en;
endmodule

// File: doc/gb_sweep_unit.md
Name: gb_sweep_unit

Overview:
Frequency sweep unit for square channel 1 (NR10), directly downstream of the frame sequencer. It consumes the 128 Hz sweep_clk strobe and the trigger event, and keeps an 11-bit shadow frequency. It periodically recomputes the channel period and, on overflow, tells the channel to disable itself. Its freq_out drives the channel-1 frequency timer.

Parameters:
FREQ_W, 11, frequency/period width (NR13/NR14 period)
OVF_LIMIT, 2047, largest legal frequency; any result above this is overflow

Ports:
clk  input  1  system clock (2^22 Hz)
reset  input  1  asynchronous reset, active-low (asserted when 0)
sweep_clk  input  1  one-cycle strobe from the frame sequencer (128 Hz)
trigger  input  1  one-cycle channel-1 trigger strobe (NR14 bit 7 write)
nr10_period  input  3  sweep pace
nr10_negate  input  1  1 = subtract, 0 = add
nr10_shift  input  3  sweep shift amount
freq_in  input  FREQ_W  channel-1 period from NR13/NR14; sampled on trigger
freq_out  output  FREQ_W  current channel frequency (registered)
freq_update  output  1  one-cycle pulse when freq_out changes due to sweep
channel_disable  output  1  one-cycle pulse requesting channel-1 off
sweep_enabled  output  1  internal sweep-enable flag (level)

Behaviour:
- Reset (reset==0, async): shadow=0, freq_out=0, timer=0, sweep_enabled=0, neg_used=0, state=IDLE, freq_update=0, channel_disable=0.
- calc(): sum = shadow ± (shadow >> nr10_shift). The computation is 12 bits wide and unsigned. Negate never underflows. overflow = sum > OVF_LIMIT. A calc with nr10_negate=1 sets neg_used.
- Timer: 4-bit down counter. Reload value = nr10_period, or 8 if nr10_period==0.
- Trigger, sampled at edge T:
  - shadow=freq_in and freq_out=freq_in.
  - Timer is reloaded and neg_used is cleared.
  - sweep_enabled = (nr10_period!=0) || (nr10_shift!=0).
  - If nr10_shift!=0, go to CHECK. Otherwise go to IDLE.
  - Trigger aborts any in-flight state. A sweep_clk in the same cycle is ignored.
- sweep_clk in IDLE:
  - If timer!=0, decrement it. If the result is 0, the sweep expires.
  - On expiry: reload the timer.
  - If sweep_enabled && nr10_period!=0, go to CALC. Otherwise stay in IDLE.
- sweep_clk outside IDLE is ignored; the architecture guarantees at least 8192 cycles between strobes.
- FSM states:
  - IDLE: waits for trigger or an expiring sweep_clk.
  - CALC: registers calc() into new_freq. Next state is APPLY.
  - APPLY:
    - If new_freq overflows: pulse channel_disable, clear sweep_enabled, go to IDLE.
    - Else if nr10_shift!=0: shadow=freq_out=new_freq, pulse freq_update, go to CHECK.
    - Else (shift==0): go to IDLE with no write.
  - CHECK: runs calc() on the current shadow and discards the result. If it overflows, pulse channel_disable and clear sweep_enabled. Next state is IDLE.
- Latency, counted from the sweep_clk edge T:
  - freq_update pulse is high in cycle T+2.
  - Second-check channel_disable is high in cycle T+3.
  - Trigger overflow check: channel_disable is high in cycle T+1 after the trigger edge.
- Negate quirk: nr10_negate is registered each cycle. A 1->0 transition while neg_used==1 pulses channel_disable on the next cycle and clears sweep_enabled.
- Simultaneous channel_disable sources in the same cycle produce a single pulse.
- Once disabled, no sweep writes occur until the next trigger. The timer keeps counting.
- NR10 writes take effect immediately for later calcs. The timer is not reloaded by NR10 writes.
- Deasserting reset mid-operation returns the unit to IDLE with all state cleared. No pulses are emitted during reset or on the release edge.

Test Plan:
- freq_in=1024, shift=1, period=1, add, trigger:
  - The trigger check computes 1536 and does not disable.
  - On the 1st sweep_clk, freq_out=1536 with a freq_update pulse at T+2.
  - The check computes 2304, so channel_disable pulses at T+3 and sweep_enabled=0.
- freq_in=1024, shift=2, negate=1, period=2, trigger:
  - The 1st sweep_clk produces no update.
  - The 2nd sweep_clk gives freq_out=768, then 576 after the next two strobes.
  - channel_disable never pulses.
- freq_in=1500, shift=1, trigger -> channel_disable pulses 1 cycle after the trigger edge; later strobes leave freq_out=1500.
- period=0, shift=3, freq_in=200, trigger -> sweep_enabled=1, but 16 strobes produce no freq_update and freq_out stays 200.
- negate=1, shift=1, period=1, freq_in=800:
  - The trigger check sets neg_used.
  - Writing negate=0 makes channel_disable pulse once.
  - Repeating the sequence without a trigger check (shift=0 at trigger) produces no pulse.
- Assert reset mid-CALC after a sweep_clk -> all outputs go to 0 immediately, with no freq_update or channel_disable after release.
